// File: rtl/mouse_motion_accumulator.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mouse_motion_accumulator                                     |
// | Description : Turns USB HID boot-mouse reports (signed 8-bit dX/dY plus    |
// |               button bits) into an absolute, screen-clamped pointer        |
// |               position. Deltas are collected between frames and applied    |
// |               once per frame_tick. Produces one-cycle left/right click     |
// |               pulses aligned with the position update.                     |
// | Ports       : Clk, Reset (sync, active-high)                               |
// |               frame_tick      - one-cycle pulse per video frame            |
// |               report_valid    - report_* fields valid this cycle           |
// |               report_dx/dy    - signed deltas (+x right, +y down)          |
// |               report_buttons  - [0]=left [1]=right [2]=middle              |
// |               x/y_displacement- absolute position, 0..X_MAX / 0..Y_MAX     |
// |               left/right_click- one-cycle pulse after a frame_tick         |
// |               left_held       - registered level of the left button        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module mouse_motion_accumulator #(
  parameter int X_MAX    = 624,
  parameter int Y_MAX    = 464,
  parameter int X_RESET  = 320,
  parameter int Y_RESET  = 240,
  parameter int ACC_W    = 12,   // must exceed 8 so a raw delta always fits
  parameter int INVERT_Y = 0
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        frame_tick,
  input  logic        report_valid,
  input  logic [7:0]  report_dx,
  input  logic [7:0]  report_dy,
  input  logic [2:0]  report_buttons,
  output logic [15:0] x_displacement,
  output logic [15:0] y_displacement,
  output logic        left_click,
  output logic        right_click,
  output logic        left_held
);

  localparam int POS_W = 16;
  // Position + accumulator sum width: two guard bits over the wider operand
  // so neither a full-scale accumulator nor a 16-bit position can overflow.
  localparam int SUM_W = ((ACC_W > POS_W) ? ACC_W : POS_W) + 2;

  // Symmetric saturation limits: +/-(2^(ACC_W-1)-1).
  localparam logic signed [ACC_W-1:0] C_ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] C_ACC_MIN = {1'b1, {(ACC_W-2){1'b0}}, 1'b1};
  localparam logic signed [ACC_W:0]   C_SUM_MAX = {2'b00, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W:0]   C_SUM_MIN = {2'b11, {(ACC_W-2){1'b0}}, 1'b1};

  localparam logic [POS_W-1:0] C_X_RESET = POS_W'(X_RESET);
  localparam logic [POS_W-1:0] C_Y_RESET = POS_W'(Y_RESET);

  // --------------------------------------------------------------------------
  // Helpers
  // --------------------------------------------------------------------------
  function automatic logic signed [ACC_W-1:0] sat_add(
    input logic signed [ACC_W-1:0] a,
    input logic signed [ACC_W-1:0] b
  );
    logic signed [ACC_W:0] s;
    s = $signed({a[ACC_W-1], a}) + $signed({b[ACC_W-1], b});
    if (s > C_SUM_MAX) begin
      sat_add = C_ACC_MAX;
    end else if (s < C_SUM_MIN) begin
      sat_add = C_ACC_MIN;
    end else begin
      sat_add = s[ACC_W-1:0];
    end
  endfunction

  // Applies a signed delta to an unsigned position and clamps to [0, max_v].
  function automatic logic [POS_W-1:0] move_clamp(
    input logic [POS_W-1:0]        pos,
    input logic signed [ACC_W-1:0] delta,
    input int                      max_v
  );
    logic signed [SUM_W-1:0] pos_ext;
    logic signed [SUM_W-1:0] dlt_ext;
    logic signed [SUM_W-1:0] lim;
    logic signed [SUM_W-1:0] nx;
    pos_ext = {{(SUM_W-POS_W){1'b0}}, pos};
    dlt_ext = {{(SUM_W-ACC_W){delta[ACC_W-1]}}, delta};
    lim     = SUM_W'(max_v);
    nx      = pos_ext + dlt_ext;
    if (nx < 0) begin
      move_clamp = '0;
    end else if (nx > lim) begin
      move_clamp = POS_W'(lim);
    end else begin
      move_clamp = POS_W'(nx);
    end
  endfunction

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [POS_W-1:0]        x_q, x_d;
  logic [POS_W-1:0]        y_q, y_d;
  logic signed [ACC_W-1:0] acc_dx_q, acc_dx_d;
  logic signed [ACC_W-1:0] acc_dy_q, acc_dy_d;
  logic                    pend_left_q, pend_left_d;
  logic                    pend_right_q, pend_right_d;
  logic [1:0]              last_buttons_q, last_buttons_d;
  logic                    left_click_q, left_click_d;
  logic                    right_click_q, right_click_d;
  logic                    left_held_q, left_held_d;

  // The middle button is carried in the report but has no consumer here.
  logic w_unused_middle;
  assign w_unused_middle = report_buttons[2];

  // --------------------------------------------------------------------------
  // Report decode
  // --------------------------------------------------------------------------
  logic signed [ACC_W-1:0] w_dx_ext;
  logic signed [ACC_W-1:0] w_dy_sext;
  logic signed [ACC_W-1:0] w_dy_ext;
  logic                    w_left_edge;
  logic                    w_right_edge;

  assign w_dx_ext  = {{(ACC_W-8){report_dx[7]}}, report_dx};
  assign w_dy_sext = {{(ACC_W-8){report_dy[7]}}, report_dy};
  // Negation is done after sign extension so -128 becomes +128 without wrap.
  assign w_dy_ext  = (INVERT_Y != 0) ? -w_dy_sext : w_dy_sext;

  assign w_left_edge  = report_valid & report_buttons[0] & ~last_buttons_q[0];
  assign w_right_edge = report_valid & report_buttons[1] & ~last_buttons_q[1];

  // --------------------------------------------------------------------------
  // Next state
  // --------------------------------------------------------------------------
  // Effective accumulators and pending flags include a report arriving in the
  // same cycle, so a report coincident with frame_tick lands in this update.
  logic signed [ACC_W-1:0] w_acc_dx_eff;
  logic signed [ACC_W-1:0] w_acc_dy_eff;
  logic                    w_pend_left_eff;
  logic                    w_pend_right_eff;

  always_comb begin
    w_acc_dx_eff     = acc_dx_q;
    w_acc_dy_eff     = acc_dy_q;
    w_pend_left_eff  = pend_left_q | w_left_edge;
    w_pend_right_eff = pend_right_q | w_right_edge;
    last_buttons_d   = last_buttons_q;
    left_held_d      = left_held_q;

    if (report_valid) begin
      w_acc_dx_eff   = sat_add(acc_dx_q, w_dx_ext);
      w_acc_dy_eff   = sat_add(acc_dy_q, w_dy_ext);
      last_buttons_d = report_buttons[1:0];
      left_held_d    = report_buttons[0];
    end
  end

  always_comb begin
    x_d           = x_q;
    y_d           = y_q;
    acc_dx_d      = w_acc_dx_eff;
    acc_dy_d      = w_acc_dy_eff;
    pend_left_d   = w_pend_left_eff;
    pend_right_d  = w_pend_right_eff;
    left_click_d  = 1'b0;
    right_click_d = 1'b0;

    if (frame_tick) begin
      x_d           = move_clamp(x_q, w_acc_dx_eff, X_MAX);
      y_d           = move_clamp(y_q, w_acc_dy_eff, Y_MAX);
      acc_dx_d      = '0;
      acc_dy_d      = '0;
      pend_left_d   = 1'b0;
      pend_right_d  = 1'b0;
      left_click_d  = w_pend_left_eff;
      right_click_d = w_pend_right_eff;
    end
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge Clk) begin
    if (Reset) begin
      x_q            <= C_X_RESET;
      y_q            <= C_Y_RESET;
      acc_dx_q       <= '0;
      acc_dy_q       <= '0;
      pend_left_q    <= 1'b0;
      pend_right_q   <= 1'b0;
      last_buttons_q <= '0;
      left_click_q   <= 1'b0;
      right_click_q  <= 1'b0;
      left_held_q    <= 1'b0;
    end else begin
      x_q            <= x_d;
      y_q            <= y_d;
      acc_dx_q       <= acc_dx_d;
      acc_dy_q       <= acc_dy_d;
      pend_left_q    <= pend_left_d;
      pend_right_q   <= pend_right_d;
      last_buttons_q <= last_buttons_d;
      left_click_q   <= left_click_d;
      right_click_q  <= right_click_d;
      left_held_q    <= left_held_d;
    end
  end

  assign x_displacement = x_q;
  assign y_displacement = y_q;
  assign left_click     = left_click_q;
  assign right_click    = right_click_q;
  assign left_held      = left_held_q;

endmodule
`default_nettype wire

// File: tb/tb_mouse_motion_accumulator.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_mouse_motion_accumulator                                  |
// | Description : Self-checking bench for mouse_motion_accumulator. A vector   |
// |               table with hand-derived expectations plus hand-written       |
// |               multi-cycle sequences; a behavioural model feeds a           |
// |               per-cycle scoreboard queue.                                  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_mouse_motion_accumulator;

  logic        Clk;
  logic        Reset;
  logic        frame_tick;
  logic        report_valid;
  logic [7:0]  report_dx;
  logic [7:0]  report_dy;
  logic [2:0]  report_buttons;
  logic [15:0] x_displacement;
  logic [15:0] y_displacement;
  logic        left_click;
  logic        right_click;
  logic        left_held;

  mouse_motion_accumulator dut (
    .Clk            (Clk),
    .Reset          (Reset),
    .frame_tick     (frame_tick),
    .report_valid   (report_valid),
    .report_dx      (report_dx),
    .report_dy      (report_dy),
    .report_buttons (report_buttons),
    .x_displacement (x_displacement),
    .y_displacement (y_displacement),
    .left_click     (left_click),
    .right_click    (right_click),
    .left_held      (left_held)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    bit       rst;
    bit       valid;
    int       dx;
    int       dy;
    bit [2:0] btn;
    bit       tick;
    int       ex;
    int       ey;
    bit       elc;
    bit       erc;
    bit       elh;
  } vec_t;

  typedef struct {
    int x;
    int y;
    bit lc;
    bit rc;
    bit lh;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];

  // Behavioural reference model
  int       m_x, m_y, m_ax, m_ay;
  bit       m_pl, m_pr, m_lc, m_rc, m_lh;
  bit [1:0] m_last;

  function automatic int sat(int v);
    if (v > 2047)  return 2047;
    if (v < -2047) return -2047;
    return v;
  endfunction

  function automatic int clampi(int v, int hi);
    if (v < 0)  return 0;
    if (v > hi) return hi;
    return v;
  endfunction

  task automatic model_step(bit rst, bit valid, int dx, int dy, bit [2:0] btn, bit tick);
    if (rst) begin
      m_x = 320; m_y = 240; m_ax = 0; m_ay = 0;
      m_pl = 0; m_pr = 0; m_lc = 0; m_rc = 0; m_lh = 0; m_last = 2'b00;
    end else begin
      if (valid) begin
        m_ax = sat(m_ax + dx);
        m_ay = sat(m_ay + dy);
        if (btn[0] && !m_last[0]) m_pl = 1;
        if (btn[1] && !m_last[1]) m_pr = 1;
        m_last = btn[1:0];
        m_lh   = btn[0];
      end
      if (tick) begin
        m_x  = clampi(m_x + m_ax, 624);
        m_y  = clampi(m_y + m_ay, 464);
        m_ax = 0; m_ay = 0;
        m_lc = m_pl; m_rc = m_pr;
        m_pl = 0; m_pr = 0;
      end else begin
        m_lc = 0; m_rc = 0;
      end
    end
  endtask

  // Drive one cycle of stimulus on the falling edge and queue the expectation.
  task automatic drive(bit rst, bit valid, int dx, int dy, bit [2:0] btn, bit tick);
    exp_t e;
    @(negedge Clk);
    Reset          = rst;
    report_valid   = valid;
    report_dx      = 8'(dx);
    report_dy      = 8'(dy);
    report_buttons = btn;
    frame_tick     = tick;
    model_step(rst, valid, dx, dy, btn, tick);
    e.x = m_x; e.y = m_y; e.lc = m_lc; e.rc = m_rc; e.lh = m_lh;
    sb.push_back(e);
  endtask

  task automatic check(string nm, int act, int exp_v);
    n_checks++;
    if (act != exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp_v);
    end
  endtask

  // Scoreboard: one queued expectation per driven cycle, compared after the edge.
  always @(posedge Clk) begin
    exp_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      n_checks++;
      if (x_displacement != 16'(e.x) || y_displacement != 16'(e.y) ||
          left_click != e.lc || right_click != e.rc || left_held != e.lh) begin
        n_fail++;
        $display("FAIL scoreboard @%0t: got x=%0d y=%0d lc=%0b rc=%0b lh=%0b, expected x=%0d y=%0d lc=%0b rc=%0b lh=%0b",
                 $time, x_displacement, y_displacement, left_click, right_click, left_held,
                 e.x, e.y, e.lc, e.rc, e.lh);
      end
    end
  end

  function automatic void add(bit rst, bit valid, int dx, int dy, bit [2:0] btn, bit tick,
                              int ex, int ey, bit elc, bit erc, bit elh);
    vec_t v;
    v.rst = rst; v.valid = valid; v.dx = dx; v.dy = dy; v.btn = btn; v.tick = tick;
    v.ex = ex; v.ey = ey; v.elc = elc; v.erc = erc; v.elh = elh;
    tbl.push_back(v);
  endfunction

  task automatic tick_and_check(string nm, int ex, int ey, bit elc);
    drive(0, 0, 0, 0, 3'b000, 1);
    @(posedge Clk);
    #2;
    check({nm, "_x"}, int'(x_displacement), ex);
    check({nm, "_y"}, int'(y_displacement), ey);
    check({nm, "_lclick"}, int'(left_click), int'(elc));
  endtask

  initial begin
    Reset = 1'b1; frame_tick = 1'b0; report_valid = 1'b0;
    report_dx = '0; report_dy = '0; report_buttons = '0;

    //   rst valid  dx   dy   btn    tick   x    y   lc rc lh
    add(1, 0,    0,   0, 3'b000, 0,   320, 240, 0, 0, 0);  // reset
    add(0, 0,    0,   0, 3'b000, 1,   320, 240, 0, 0, 0);  // tick, no motion
    add(0, 1,   10,   0, 3'b000, 0,   320, 240, 0, 0, 0);
    add(0, 1,    5,   0, 3'b000, 0,   320, 240, 0, 0, 0);
    add(0, 1,   -3,   0, 3'b000, 0,   320, 240, 0, 0, 0);
    add(0, 0,    0,   0, 3'b000, 1,   332, 240, 0, 0, 0);  // +12 applied
    add(0, 0,    0,   0, 3'b000, 1,   332, 240, 0, 0, 0);  // no change
    add(0, 1,    0,   0, 3'b001, 0,   332, 240, 0, 0, 1);  // left press
    add(0, 1,    0,   0, 3'b001, 0,   332, 240, 0, 0, 1);  // held
    add(0, 0,    0,   0, 3'b000, 1,   332, 240, 1, 0, 1);  // one pulse
    add(0, 0,    0,   0, 3'b000, 0,   332, 240, 0, 0, 1);  // pulse gone
    add(0, 0,    0,   0, 3'b000, 1,   332, 240, 0, 0, 1);  // no pulse again
    add(0, 1, -128,   0, 3'b001, 0,   332, 240, 0, 0, 1);
    add(0, 1, -104,   0, 3'b000, 0,   332, 240, 0, 0, 0);  // release
    add(0, 0,    0,   0, 3'b000, 1,   100, 240, 0, 0, 0);  // x=100
    add(0, 1,    4,   0, 3'b001, 1,   104, 240, 1, 0, 1);  // report with tick
    add(0, 0,    0,   0, 3'b000, 1,   104, 240, 0, 0, 1);  // nothing doubled
    add(0, 1,    0, -40, 3'b010, 0,   104, 240, 0, 0, 0);  // right press
    add(0, 0,    0,   0, 3'b000, 1,   104, 200, 0, 1, 0);
    add(0, 0,    0,   0, 3'b000, 0,   104, 200, 0, 0, 0);
    add(0, 1,   20,  10, 3'b000, 0,   104, 200, 0, 0, 0);  // press ignored w/o valid:
    add(0, 0,    0,   0, 3'b011, 0,   104, 200, 0, 0, 0);
    add(0, 0,    0,   0, 3'b000, 1,   124, 210, 0, 0, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].rst, tbl[i].valid, tbl[i].dx, tbl[i].dy, tbl[i].btn, tbl[i].tick);
      @(posedge Clk);
      #2;
      check($sformatf("vec%0d_x", i), int'(x_displacement), tbl[i].ex);
      check($sformatf("vec%0d_y", i), int'(y_displacement), tbl[i].ey);
      check($sformatf("vec%0d_clicks", i), int'({left_click, right_click, left_held}),
            int'({tbl[i].elc, tbl[i].erc, tbl[i].elh}));
    end

    // Large negative motion clamps at the left edge.
    drive(1, 0, 0, 0, 3'b000, 0);
    for (int i = 0; i < 10; i++) drive(0, 1, -128, 0, 3'b000, 0);
    tick_and_check("clamp_left", 0, 240, 0);

    // Large positive dy clamps at the bottom edge.
    drive(1, 0, 0, 0, 3'b000, 0);
    for (int i = 0; i < 10; i++) drive(0, 1, 0, 127, 3'b000, 0);
    tick_and_check("clamp_bottom", 320, 464, 0);

    // Saturated accumulator (2047) still clamps to X_MAX.
    drive(1, 0, 0, 0, 3'b000, 0);
    for (int i = 0; i < 300; i++) drive(0, 1, 127, 0, 3'b000, 0);
    tick_and_check("sat_pos", 624, 240, 0);

    // Negative saturation (-2047) from X_MAX clamps to 0.
    for (int i = 0; i < 300; i++) drive(0, 1, -128, -128, 3'b000, 0);
    tick_and_check("sat_neg", 0, 0, 0);

    // Reset mid-accumulation discards motion and a pending click.
    for (int i = 0; i < 20; i++) drive(0, 1, 50, 30, 3'b001, 0);
    drive(1, 0, 0, 0, 3'b000, 0);
    tick_and_check("mid_reset", 320, 240, 0);

    repeat (2) @(posedge Clk);
    #3;
    check("sb_drain", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
